// File: rtl/spi_pkg.sv
// spi_pkg: SPI state encoding and default frame parameters shared by master and slave benches
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_CLK_DIV = 2;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE} spi_state_t;
endpackage

// File: rtl/spi_phase_cnt.sv
// spi_phase_cnt: loadable down-counter; tc is high while the count sits at zero
module spi_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/spi_master.sv
// spi_master: single-word SPI master, SCLK idle low, MSB first, MISO sampled on SCLK fall.
// SPI_MASTER_LOOPBACK_EN adds a loopback input that samples the MOSI register instead of MISO.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W,
  parameter int CLK_DIV  = SPI_CLK_DIV,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              SCLK,
  output logic              CS,
  output logic              MOSI,
  input  logic              MISO
);
  // HOLD also covers the final SCLK low half-period so the frame is 2*CLK_DIV per bit
  localparam int HOLD_LEN = CLK_DIV + CS_HOLD;
  localparam int MAX_LEN = (CS_SETUP > HOLD_LEN) ? CS_SETUP : HOLD_LEN;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int BW = $clog2(DATA_W);
  spi_state_t state, next_state;
  logic load, tc, last_bit, sample;
  logic [CW-1:0] load_val;
  logic [BW-1:0] bits_sent;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  spi_phase_cnt #(.W(CW)) u_cnt (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .tc(tc)
  );
  assign last_bit = bits_sent == BW'(DATA_W - 1);
`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample = loopback ? MOSI : MISO;
`else
  assign sample = MISO;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    load = 1'b0;
    load_val = '0;
    case (state)
      IDLE: if (start) begin
        next_state = SETUP;
        load = 1'b1;
        load_val = CW'(CS_SETUP - 1);
      end
      SETUP: if (tc) begin
        next_state = SHIFT_HI;
        load = 1'b1;
        load_val = CW'(CLK_DIV - 1);
      end
      SHIFT_HI: if (tc) begin
        next_state = last_bit ? HOLD : SHIFT_LO;
        load = 1'b1;
        load_val = last_bit ? CW'(HOLD_LEN - 1) : CW'(CLK_DIV - 1);
      end
      SHIFT_LO: if (tc) begin
        next_state = SHIFT_HI;
        load = 1'b1;
        load_val = CW'(CLK_DIV - 1);
      end
      HOLD: if (tc) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      CS <= 1'b1;
      SCLK <= 1'b0;
      MOSI <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rx_data <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      bits_sent <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tx_sr <= tx_data;
          CS <= 1'b0;
          MOSI <= tx_data[DATA_W-1];
          busy <= 1'b1;
          bits_sent <= '0;
        end
        SETUP: if (tc) SCLK <= 1'b1;
        SHIFT_HI: if (tc) begin
          SCLK <= 1'b0;
          rx_sr <= {rx_sr[DATA_W-2:0], sample};
          if (!last_bit) begin
            MOSI <= tx_sr[DATA_W-2];
            tx_sr <= tx_sr << 1;
            bits_sent <= bits_sent + 1'b1;
          end
        end
        SHIFT_LO: if (tc) SCLK <= 1'b1;
        HOLD: if (tc) begin
          CS <= 1'b1;
          rx_data <= rx_sr;
          done <= 1'b1;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule
